wb_trace_buffer: RTL and testbench

Commit-trace capture block that sits directly downstream of the pipelined processor's MEM/WB write-back port. Each cycle it samples the retiring register write (PC, destination register, data). Qualifying commits are pushed into an internal FIFO. The bench or debug logic drains the FIFO later through a valid/ready port. A small arm/stop state machine controls the capture window, and overflow is tracked so trace gaps are never silent.

---
 rtl/wb_trace_buffer_if.sv | 25 ++
 rtl/wb_trace_buffer.sv | 142 ++++++++++++++
 tb/tb_wb_trace_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_buffer_if.sv
// Write-back commit port and trace read port of wb_trace_buffer.
// The master side drives commits and consumes trace entries; the buffer is the slave.
interface wb_trace_buffer_if #(
    parameter int WORD_SIZE = 32
);
    logic                 wb_valid;
    logic [4:0]           wb_addr;
    logic [WORD_SIZE-1:0] wb_data;
    logic [WORD_SIZE-1:0] wb_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_addr;
    logic [WORD_SIZE-1:0] out_data;
    logic [WORD_SIZE-1:0] out_pc;

    modport master (
        output wb_valid, wb_addr, wb_data, wb_pc, out_ready,
        input  out_valid, out_addr, out_data, out_pc
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, wb_pc, out_ready,
        output out_valid, out_addr, out_data, out_pc
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture FIFO behind the MEM/WB write-back port, with an
// arm/stop capture window and sticky overflow / saturating drop accounting.
module wb_trace_buffer #(
    parameter int WORD_SIZE    = 32,
    parameter int DEPTH        = 16,
    parameter int FILTER_R0    = 1,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     arm_i,
    input  logic                     stop_i,
    wb_trace_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              dropped_o,
    output logic [1:0]               state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e               state_q;
    logic                 overflow_q;
    logic [15:0]          dropped_q;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [WORD_SIZE-1:0] pc_mem_q   [DEPTH];
    logic [WORD_SIZE-1:0] data_mem_q [DEPTH];
    logic [4:0]           addr_mem_q [DEPTH];

    logic filtered_s, qual_s, full_s, nonempty_s, pop_s, push_s, drop_s;

    // Commit qualification and push/pop/drop decisions for this cycle.
    always_comb begin
        filtered_s = (FILTER_R0 != 0) && (bus.wb_addr == 5'd0);
        qual_s     = (state_q == ST_CAPTURE) && bus.wb_valid && !filtered_s;
        full_s     = (count_q == CW'(DEPTH));
        nonempty_s = (count_q != {CW{1'b0}});
        pop_s      = nonempty_s && bus.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_s     = qual_s && (!full_s || pop_s);
        drop_s     = qual_s && full_s && !pop_s;
    end

    // Next-state of occupancy and pointers; pointers wrap at the power-of-two depth.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= {CW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observable while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= bus.wb_pc;
            addr_mem_q[wr_ptr_q] <= bus.wb_addr;
            data_mem_q[wr_ptr_q] <= bus.wb_data;
        end
    end

    // Capture-window FSM with overflow and drop accounting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            dropped_q  <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_q    <= ST_CAPTURE;
                        overflow_q <= 1'b0;
                        dropped_q  <= 16'h0000;
                    end
                end
                ST_CAPTURE: begin
                    if (drop_s) begin
                        overflow_q <= 1'b1;
                        if (dropped_q != 16'hFFFF) begin
                            dropped_q <= dropped_q + 16'h0001;
                        end
                    end
                    if (stop_i || ((STOP_ON_FULL != 0) && drop_s)) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // First-word-fall-through head view; zero while empty.
    always_comb begin
        bus.out_valid = nonempty_s;
        if (nonempty_s) begin
            bus.out_pc   = pc_mem_q[rd_ptr_q];
            bus.out_addr = addr_mem_q[rd_ptr_q];
            bus.out_data = data_mem_q[rd_ptr_q];
        end else begin
            bus.out_pc   = {WORD_SIZE{1'b0}};
            bus.out_addr = 5'd0;
            bus.out_data = {WORD_SIZE{1'b0}};
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign dropped_o  = dropped_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomised and directed bench for wb_trace_buffer: two instances (STOP_ON_FULL 0 and 1)
// share stimulus and are compared each cycle against a queue-based model.
module tb_wb_trace_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0, stop = 1'b0, wv = 1'b0, rdy = 1'b0;
    logic [4:0]  wa = 5'd0;
    logic [31:0] wd = 32'd0, wp = 32'd0;

    logic [4:0]  cnt0, cnt1;
    logic        ov0, ov1;
    logic [15:0] dr0, dr1;
    logic [1:0]  st0, st1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_trace_buffer_if #(.WORD_SIZE(32)) bus0 ();
    wb_trace_buffer_if #(.WORD_SIZE(32)) bus1 ();

    assign bus0.wb_valid = wv;  assign bus1.wb_valid = wv;
    assign bus0.wb_addr  = wa;  assign bus1.wb_addr  = wa;
    assign bus0.wb_data  = wd;  assign bus1.wb_data  = wd;
    assign bus0.wb_pc    = wp;  assign bus1.wb_pc    = wp;
    assign bus0.out_ready = rdy; assign bus1.out_ready = rdy;

    wb_trace_buffer #(.WORD_SIZE(32), .DEPTH(16), .FILTER_R0(1), .STOP_ON_FULL(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .stop_i(stop), .bus(bus0.slave),
        .count_o(cnt0), .overflow_o(ov0), .dropped_o(dr0), .state_o(st0));

    wb_trace_buffer #(.WORD_SIZE(32), .DEPTH(16), .FILTER_R0(1), .STOP_ON_FULL(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .stop_i(stop), .bus(bus1.slave),
        .count_o(cnt1), .overflow_o(ov1), .dropped_o(dr1), .state_o(st1));

    // Model: entries are {pc, addr, data}; state 0 idle, 1 capturing, 2 done.
    logic [68:0] q0[$];
    logic [68:0] q1[$];
    int  mst[2] = '{0, 0};
    bit  mov[2] = '{1'b0, 1'b0};
    int  mdr[2] = '{0, 0};
    bit  sof[2] = '{1'b0, 1'b1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mov[k] = 1'b0; mdr[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic [68:0] tq[$];
        bit qual, pop, drop;
        if (k == 0) tq = q0; else tq = q1;
        qual = (mst[k] == 1) && wv && (wa != 5'd0);
        pop  = (tq.size() != 0) && rdy;
        drop = 1'b0;
        if (pop) void'(tq.pop_front());
        if (qual) begin
            if (tq.size() < 16) tq.push_back({wp, wa, wd});
            else begin
                drop = 1'b1;
                mov[k] = 1'b1;
                if (mdr[k] < 65535) mdr[k]++;
            end
        end
        if (mst[k] == 1) begin
            if (stop || (sof[k] && drop)) mst[k] = 2;
        end else if (arm) begin
            mst[k] = 1; mov[k] = 1'b0; mdr[k] = 0;
        end
        if (k == 0) q0 = tq; else q1 = tq;
    endtask

    // Model advance on every clock edge and on asynchronous reset.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic cmp(input int k, input logic [4:0] c, input logic o, input logic v,
                       input logic [4:0] a, input logic [31:0] d, input logic [31:0] p,
                       input logic [15:0] r, input logic [1:0] s);
        logic [68:0] h;
        int sz;
        if (k == 0) begin sz = q0.size(); h = (sz != 0) ? q0[0] : 69'd0; end
        else        begin sz = q1.size(); h = (sz != 0) ? q1[0] : 69'd0; end
        chk($sformatf("u%0d.count", k), {27'd0, c}, sz);
        chk($sformatf("u%0d.out_valid", k), {31'd0, v}, {31'd0, (sz != 0)});
        chk($sformatf("u%0d.out_pc", k), p, h[68:37]);
        chk($sformatf("u%0d.out_addr", k), {27'd0, a}, {27'd0, h[36:32]});
        chk($sformatf("u%0d.out_data", k), d, h[31:0]);
        chk($sformatf("u%0d.overflow", k), {31'd0, o}, {31'd0, mov[k]});
        chk($sformatf("u%0d.dropped", k), {16'd0, r}, mdr[k]);
        chk($sformatf("u%0d.state", k), {30'd0, s}, mst[k]);
    endtask

    // Every-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        cmp(0, cnt0, ov0, bus0.out_valid, bus0.out_addr, bus0.out_data, bus0.out_pc, dr0, st0);
        cmp(1, cnt1, ov1, bus1.out_valid, bus1.out_addr, bus1.out_data, bus1.out_pc, dr1, st1);
    end

    task automatic cyc(input logic a_arm, input logic a_stop, input logic a_wv, input logic [4:0] a_wa,
                       input logic [31:0] a_wd, input logic [31:0] a_wp, input logic a_rdy);
        arm = a_arm; stop = a_stop; wv = a_wv; wa = a_wa; wd = a_wd; wp = a_wp; rdy = a_rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then commits while idle are ignored.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 5'd5, 32'h55, 32'h100, 1'b0);
        chk("idle.count", {27'd0, cnt0}, 32'd0);
        chk("idle.out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("idle.state", {30'd0, st0}, 32'd0);

        // Basic capture with r0 filtered.
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 5'd8, 32'h11, 32'h04, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 5'd9, 32'h22, 32'h08, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 5'd0, 32'h33, 32'h0C, 1'b0);
        chk("basic.count", {27'd0, cnt0}, 32'd2);
        chk("basic.out_pc", bus0.out_pc, 32'h04);
        chk("basic.out_addr", {27'd0, bus0.out_addr}, 32'd8);
        chk("basic.out_data", bus0.out_data, 32'h11);

        // Drain order.
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        chk("drain.addr2", {27'd0, bus0.out_addr}, 32'd9);
        chk("drain.data2", bus0.out_data, 32'h22);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        chk("drain.count", {27'd0, cnt0}, 32'd0);
        chk("drain.out_valid", {31'd0, bus0.out_valid}, 32'd0);

        // Overflow: 20 commits into 16 entries.
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b0, 1'b1, 5'(1 + i), 32'h1000 + i, 32'h200 + 4 * i, 1'b0);
        chk("ovf.count", {27'd0, cnt0}, 32'd16);
        chk("ovf.overflow", {31'd0, ov0}, 32'd1);
        chk("ovf.dropped", {16'd0, dr0}, 32'd4);
        chk("ovf.state", {30'd0, st0}, 32'd1);
        chk("sof.state", {30'd0, st1}, 32'd2);
        chk("sof.dropped", {16'd0, dr1}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("rearm.ignored", {30'd0, st0}, 32'd1);
        chk("rearm.dropped", {16'd0, dr0}, 32'd4);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("stop.state", {30'd0, st0}, 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("arm.overflow", {31'd0, ov0}, 32'd0);
        chk("arm.dropped", {16'd0, dr0}, 32'd0);
        chk("arm.count", {27'd0, cnt0}, 32'd16);

        // Full FIFO with simultaneous pop and push.
        cyc(1'b0, 1'b0, 1'b1, 5'd3, 32'hAB, 32'h300, 1'b1);
        chk("fullpp.count", {27'd0, cnt0}, 32'd16);
        chk("fullpp.dropped", {16'd0, dr0}, 32'd0);
        repeat (15) cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        chk("fullpp.last_count", {27'd0, cnt0}, 32'd1);
        chk("fullpp.last_addr", {27'd0, bus0.out_addr}, 32'd3);
        chk("fullpp.last_data", bus0.out_data, 32'hAB);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        chk("fullpp.empty", {27'd0, cnt0}, 32'd0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b1, 5'(10 + i), 32'h700 + i, 32'h400 + 4 * i, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.state", {30'd0, st0}, 32'd0);
        chk("arst.count", {27'd0, cnt0}, 32'd0);
        chk("arst.out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("arst.state_sof", {30'd0, st1}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                $urandom, $urandom, ($urandom_range(0, 2) == 0));
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
